// File: rtl/k_and_s_pkg.sv
// Shared K&S processor types: instruction classes produced by the decoder.
package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNZERO = 4'd10,
    I_BNEG   = 4'd11,
    I_BNNEG  = 4'd12,
    I_HALT   = 4'd13
  } decoded_instruction_type;
endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle: decoded instruction and flags in, strobes out.
interface control_unit_if;
  import k_and_s_pkg::*;

  decoded_instruction_type decoded_instruction;
  logic       zero_op;
  logic       neg_op;
  logic       unsigned_overflow;
  logic       signed_overflow;
  logic       branch;
  logic       pc_enable;
  logic       ir_enable;
  logic       addr_sel;
  logic       c_sel;
  logic [1:0] operation;
  logic       write_reg_enable;
  logic       flags_reg_enable;
  logic       ram_write_enable;
  logic       halt;
  logic       overflow_trap;

  // Strobes are level signals valid for the whole cycle of the owning state; no handshake.
  modport master (
    input  decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
    output branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
           write_reg_enable, flags_reg_enable, ram_write_enable, halt, overflow_trap
  );

  modport slave (
    output decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
    input  branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
           write_reg_enable, flags_reg_enable, ram_write_enable, halt, overflow_trap
  );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle Moore sequencer for the K&S datapath, registered outputs.
// Optional macro OVERFLOW_TRAP_EN: ADD/SUB overflow halts at the next DECODE.
module control_unit
  import k_and_s_pkg::*;
#(
  parameter logic [1:0] MOVE_OP = 2'b00
) (
  input  logic           clk,
  input  logic           rst,
  control_unit_if.master cu,
  output logic [3:0]     state_dbg
);

  typedef enum logic [3:0] {
    RST_ST, FETCH, DECODE, LOAD_ST, STORE_ST, MOVE_ST, ALU_ST, BR_ST, HALT_ST
  } state_t;

  state_t state, nxt;
  logic   z_q, n_q, flag_cap;
  logic   trap_pend, trap_next;

  assign state_dbg = state;

`ifdef OVERFLOW_TRAP_EN
  logic alu_addsub;
  assign trap_next = trap_pend |
                     (flag_cap & alu_addsub & (cu.signed_overflow | cu.unsigned_overflow));
`else
  logic unused_ov;
  assign unused_ov = cu.signed_overflow ^ cu.unsigned_overflow;
  assign trap_pend = 1'b0;
  assign trap_next = 1'b0;
`endif

  always_comb begin
    nxt = state;
    case (state)
      RST_ST:  nxt = FETCH;
      FETCH:   nxt = DECODE;
      DECODE: begin
        if (trap_pend) nxt = HALT_ST;
        else begin
          case (cu.decoded_instruction)
            I_LOAD:                    nxt = LOAD_ST;
            I_STORE:                   nxt = STORE_ST;
            I_MOVE:                    nxt = MOVE_ST;
            I_ADD, I_SUB, I_AND, I_OR: nxt = ALU_ST;
            I_BRANCH:                  nxt = BR_ST;
            I_BZERO:                   nxt = z_q  ? BR_ST : FETCH;
            I_BNZERO:                  nxt = !z_q ? BR_ST : FETCH;
            I_BNEG:                    nxt = n_q  ? BR_ST : FETCH;
            I_BNNEG:                   nxt = !n_q ? BR_ST : FETCH;
            I_HALT:                    nxt = HALT_ST;
            default:                   nxt = FETCH;
          endcase
        end
      end
      HALT_ST: nxt = HALT_ST;
      default: nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RST_ST;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      flag_cap <= 1'b0;
`ifdef OVERFLOW_TRAP_EN
      trap_pend  <= 1'b0;
      alu_addsub <= 1'b0;
`endif
      cu.branch           <= 1'b0;
      cu.pc_enable        <= 1'b0;
      cu.ir_enable        <= 1'b0;
      cu.addr_sel         <= 1'b0;
      cu.c_sel            <= 1'b0;
      cu.operation        <= 2'b00;
      cu.write_reg_enable <= 1'b0;
      cu.flags_reg_enable <= 1'b0;
      cu.ram_write_enable <= 1'b0;
      cu.halt             <= 1'b0;
      cu.overflow_trap    <= 1'b0;
    end else begin
      state <= nxt;
      // Datapath flags are only valid the cycle after ALU_ST; shadow them then.
      flag_cap <= (state == ALU_ST);
      if (flag_cap) begin
        z_q <= cu.zero_op;
        n_q <= cu.neg_op;
      end
`ifdef OVERFLOW_TRAP_EN
      trap_pend <= trap_next;
      if (state == DECODE)
        alu_addsub <= (cu.decoded_instruction == I_ADD) || (cu.decoded_instruction == I_SUB);
`endif
      cu.branch           <= 1'b0;
      cu.pc_enable        <= 1'b0;
      cu.ir_enable        <= 1'b0;
      cu.addr_sel         <= 1'b0;
      cu.c_sel            <= 1'b0;
      cu.operation        <= 2'b00;
      cu.write_reg_enable <= 1'b0;
      cu.flags_reg_enable <= 1'b0;
      cu.ram_write_enable <= 1'b0;
      cu.halt             <= 1'b0;
      cu.overflow_trap    <= 1'b0;
      case (nxt)
        FETCH: begin
          cu.addr_sel  <= 1'b1;
          cu.ir_enable <= 1'b1;
        end
        DECODE:   cu.pc_enable <= !trap_next;
        LOAD_ST: begin
          cu.c_sel            <= 1'b1;
          cu.write_reg_enable <= 1'b1;
        end
        STORE_ST: cu.ram_write_enable <= 1'b1;
        MOVE_ST: begin
          cu.operation        <= MOVE_OP;
          cu.write_reg_enable <= 1'b1;
        end
        ALU_ST: begin
          case (cu.decoded_instruction)
            I_ADD:   cu.operation <= 2'b01;
            I_SUB:   cu.operation <= 2'b10;
            I_AND:   cu.operation <= 2'b11;
            default: cu.operation <= 2'b00;
          endcase
          cu.write_reg_enable <= 1'b1;
          cu.flags_reg_enable <= 1'b1;
        end
        BR_ST: begin
          cu.branch    <= 1'b1;
          cu.pc_enable <= 1'b1;
        end
        HALT_ST: begin
          cu.halt          <= 1'b1;
          cu.overflow_trap <= trap_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit with an instruction-level expected-output model.
module tb_control_unit;
  import k_and_s_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] state_dbg;
  always #5 clk = ~clk;

  control_unit_if bus ();
  control_unit #(.MOVE_OP(2'b00)) dut (.clk(clk), .rst(rst), .cu(bus), .state_dbg(state_dbg));

  // {overflow_trap, halt, ram_we, flags_en, wr_en, op[1:0], c_sel, addr_sel, ir_en, pc_en, branch}
  localparam logic [11:0] W_ZERO   = 12'h000;
  localparam logic [11:0] W_FETCH  = 12'h00C;
  localparam logic [11:0] W_DEC    = 12'h002;
  localparam logic [11:0] W_DEC_T  = 12'h000;
  localparam logic [11:0] W_LOAD   = 12'h090;
  localparam logic [11:0] W_STORE  = 12'h200;
  localparam logic [11:0] W_MOVE   = 12'h080;
  localparam logic [11:0] W_ALU    = 12'h180;
  localparam logic [11:0] W_BR     = 12'h003;
  localparam logic [11:0] W_HALT   = 12'h400;
  localparam logic [11:0] W_HALT_T = 12'hC00;

  logic [11:0] dut_w;
  assign dut_w = {bus.overflow_trap, bus.halt, bus.ram_write_enable, bus.flags_reg_enable,
                  bus.write_reg_enable, bus.operation, bus.c_sel, bus.addr_sel,
                  bus.ir_enable, bus.pc_enable, bus.branch};

  logic [11:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference architectural state
  bit z_m, n_m, trap_m, last_alu, last_addsub, pz, pn, pso, puo;

  int br_cnt = 0;
  int rw_cnt = 0;
  logic [1:0] last_op = 2'b00;

  always @(negedge clk) begin
    logic [11:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (dut_w !== e) begin
        errors++;
        $display("FAIL outputs at %0t: got %h expected %h (state_dbg %0d)", $time, dut_w, e, state_dbg);
      end
    end
    if (bus.branch === 1'b1) br_cnt++;
    if (bus.ram_write_enable === 1'b1) rw_cnt++;
    if (bus.flags_reg_enable === 1'b1) last_op = bus.operation;
  end

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step(input logic [11:0] e);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic rand_inputs();
    bus.zero_op           = 1'($urandom_range(0, 1));
    bus.neg_op            = 1'($urandom_range(0, 1));
    bus.signed_overflow   = 1'($urandom_range(0, 1));
    bus.unsigned_overflow = 1'($urandom_range(0, 1));
    bus.decoded_instruction = decoded_instruction_type'(4'($urandom_range(0, 15)));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    rand_inputs();
    step(W_ZERO);
    chk("reset_outputs", dut_w, 12'h000);
    for (int i = 1; i < n; i++) step(W_ZERO);
    rst = 1'b0;
    z_m = 0; n_m = 0; trap_m = 0; last_alu = 0; last_addsub = 0;
    rand_inputs();
    step(W_FETCH);
  endtask

  task automatic halt_hold(input int n);
    for (int i = 0; i < n; i++) begin
      rand_inputs();
      step(trap_m ? W_HALT_T : W_HALT);
    end
  endtask

  // Entered with the DUT in FETCH; returns with the DUT in FETCH or HALT_ST.
  task automatic do_instr(input decoded_instruction_type ins, input bit fz, input bit fn,
                          input bit fso, input bit fuo, output bit halted);
    logic [11:0] ex;
    bit has_ex;
    halted = 0;
    rand_inputs();
    if (last_alu) begin
      bus.zero_op = pz; bus.neg_op = pn;
      bus.signed_overflow = pso; bus.unsigned_overflow = puo;
      z_m = pz; n_m = pn;
`ifdef OVERFLOW_TRAP_EN
      if (last_addsub && (pso || puo)) trap_m = 1;
`endif
    end
    last_alu = 0;
    step(trap_m ? W_DEC_T : W_DEC);
    rand_inputs();
    bus.decoded_instruction = ins;
    if (trap_m) begin
      step(W_HALT_T);
      halted = 1;
      return;
    end
    has_ex = 1;
    ex = W_ZERO;
    case (ins)
      I_LOAD:   ex = W_LOAD;
      I_STORE:  ex = W_STORE;
      I_MOVE:   ex = W_MOVE;
      I_ADD:    ex = W_ALU | 12'h020;
      I_SUB:    ex = W_ALU | 12'h040;
      I_AND:    ex = W_ALU | 12'h060;
      I_OR:     ex = W_ALU;
      I_BRANCH: ex = W_BR;
      I_BZERO:  if (z_m)  ex = W_BR; else has_ex = 0;
      I_BNZERO: if (!z_m) ex = W_BR; else has_ex = 0;
      I_BNEG:   if (n_m)  ex = W_BR; else has_ex = 0;
      I_BNNEG:  if (!n_m) ex = W_BR; else has_ex = 0;
      I_HALT:   ex = W_HALT;
      default:  has_ex = 0;
    endcase
    if (!has_ex) begin
      step(W_FETCH);
      return;
    end
    step(ex);
    if (ins == I_HALT) begin
      halted = 1;
      return;
    end
    if (ins == I_ADD || ins == I_SUB || ins == I_AND || ins == I_OR) begin
      last_alu = 1;
      last_addsub = (ins == I_ADD || ins == I_SUB);
      pz = fz; pn = fn; pso = fso; puo = fuo;
    end
    rand_inputs();
    step(W_FETCH);
  endtask

  initial begin
    bit h;
    int b0, r0;
    rst = 1'b1;
    rand_inputs();
    step(W_ZERO);
    step(W_ZERO);
    chk("reset_state", dut_w, 12'h000);
    rst = 1'b0;
    step(W_FETCH);
    chk("first_fetch", dut_w, 12'h00C);

    do_instr(I_LOAD, 0, 0, 0, 0, h);
    r0 = rw_cnt;
    do_instr(I_STORE, 0, 0, 0, 0, h);
    chk("store_pulse", 12'(rw_cnt - r0), 12'd1);

    b0 = br_cnt;
    do_instr(I_SUB, 1, 0, 0, 0, h);
    do_instr(I_BZERO, 0, 0, 0, 0, h);
    chk("bzero_taken", 12'(br_cnt - b0), 12'd1);
    do_instr(I_SUB, 0, 0, 0, 0, h);
    do_instr(I_BZERO, 0, 0, 0, 0, h);
    chk("bzero_not_taken", 12'(br_cnt - b0), 12'd1);
    do_instr(I_ADD, 0, 1, 0, 0, h);
    do_instr(I_LOAD, 0, 0, 0, 0, h);
    do_instr(I_BNEG, 0, 0, 0, 0, h);
    chk("bneg_held", 12'(br_cnt - b0), 12'd2);
    do_instr(I_AND, 0, 0, 0, 0, h);
    chk("and_op", {10'd0, last_op}, 12'd3);
    do_instr(I_OR, 0, 0, 0, 0, h);
    chk("or_op", {10'd0, last_op}, 12'd0);
    do_instr(I_MOVE, 0, 0, 0, 0, h);

    do_instr(I_HALT, 0, 0, 0, 0, h);
    halt_hold(10);
    chk("halt_held", dut_w, 12'h400);
    do_reset(1);

    // Reset while in LOAD_ST
    rand_inputs();
    step(W_DEC);
    bus.decoded_instruction = I_LOAD;
    step(W_LOAD);
    do_reset(1);

    do_instr(I_ADD, 0, 0, 1, 0, h);
    do_instr(I_NOP, 0, 0, 0, 0, h);
`ifdef OVERFLOW_TRAP_EN
    chk("trap_halt", dut_w, 12'hC00);
    halt_hold(3);
    do_reset(1);
`else
    chk("no_trap", dut_w, 12'h00C);
`endif

    for (int i = 0; i < 400; i++) begin
      decoded_instruction_type ins;
      ins = decoded_instruction_type'(4'($urandom_range(0, 15)));
      do_instr(ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), h);
      if (h) begin
        halt_hold($urandom_range(1, 4));
        do_reset($urandom_range(1, 2));
      end
    end

    @(negedge clk);
    #1;
    chk("queue_drained", 12'(exp_q.size()), 12'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
